// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
package fetch_unit_pkg;

   localparam int unsigned FETCH_XLEN = 32;

   // Instruction word that replaces a faulting fetch (addi x0, x0, 0).
   localparam logic [FETCH_XLEN-1:0] FETCH_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DROP
   } fetch_state_e;

   // One decode-side queue entry; also consumed by the decode stage.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
      logic                  fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// Small synchronous FIFO of fetch entries with a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Pop on empty is ignored; a push into a full queue only lands if a pop frees a slot.
   assign do_pop  = pop & (count != '0);
   assign do_push = push & ((count < FULL) | do_pop);
   assign head    = mem[rd_ptr];

   // Storage, pointers and occupancy; clear wins over push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding memory request at a time, results
// queued toward decode, in-flight fetches discarded on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN      = FETCH_XLEN,
   parameter int unsigned     BUF_DEPTH = 2,
   parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc,
   output logic            pc_en,
   input  logic            flush,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr,
   output logic            id_fault
);

   localparam int unsigned CW   = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

   fetch_state_e  state;
   fetch_state_e  state_n;
   logic [XLEN-1:0] pend_pc;
   logic [CW-1:0] buf_count;
   logic [CW-1:0] cnt_after;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic          push;
   logic          pop;
   logic          misaligned;
   logic          req_hs;

   assign misaligned    = (pc[1:0] != 2'b00);
   assign req_hs        = imem_req_valid & imem_req_ready;
   assign imem_req_addr = pc;

   // A pop coinciding with a flush is ignored; decode flushes its own copy.
   assign pop       = id_ready & id_valid & ~flush;
   assign cnt_after = buf_count + CW'(1) - CW'(pop);

   assign id_valid = (buf_count != '0);
   assign id_pc    = head.pc;
   assign id_instr = head.instr;
   assign id_fault = head.fault;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // PC of the request currently in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_pc <= '0;
      end else if (req_hs) begin
         pend_pc <= pc;
      end
   end

   // Next state, request issue, PC advance and queue push; flush has priority.
   always_comb begin
      state_n        = state;
      push           = 1'b0;
      push_entry     = '0;
      imem_req_valid = (state == REQ) & ~flush & ~misaligned;
      pc_en          = flush;
      case (state)
         IDLE: begin
            if (flush || (buf_count < FULL)) begin
               state_n = REQ;
            end
         end
         REQ: begin
            if (flush) begin
               state_n = REQ;
            end else if (misaligned) begin
               push       = 1'b1;
               push_entry = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
               pc_en      = 1'b1;
               state_n    = (cnt_after < FULL) ? REQ : IDLE;
            end else if (imem_req_ready) begin
               pc_en   = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (flush) begin
                  state_n = REQ;
               end else begin
                  push       = 1'b1;
                  push_entry = '{pc:    pend_pc,
                                 instr: imem_rsp_err ? NOP_INSTR : imem_rsp_data,
                                 fault: imem_rsp_err};
                  state_n    = (cnt_after < FULL) ? REQ : IDLE;
               end
            end else if (flush) begin
               state_n = DROP;
            end
         end
         DROP: begin
            // The stale response is the only thing outstanding; once it lands, resume.
            if (imem_rsp_valid) begin
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push & ~flush),
      .push_entry (push_entry),
      .pop        (pop),
      .clear      (flush),
      .count      (buf_count),
      .head       (head)
   );

endmodule
